alu_share_arbiter: RTL

- Shares one WIDTH-bit add/sub datapath (carry-in adder; subtract = A + ~B + 1) among N_REQ requesters.
- Each requester issues a one-shot operation over a valid/ready handshake.
- A round-robin arbiter grants one request at a time and sequences it through the datapath.
- The block returns a registered result tagged with the requester index; it sits between client blocks and the shared arithmetic unit.

---
 rtl/alu_share_arbiter_pkg.sv | 13 +
 rtl/alu_share_arbiter_if.sv | 37 +++
 rtl/alu_share_arbiter_rr_pick.sv | 31 +++
 rtl/alu_share_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for alu_share_arbiter: FSM state encoding and op codes.
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between client blocks and alu_share_arbiter.
// RSP_COUT exists only when ALU_SHARE_CARRY_OUT_EN is defined.
interface alu_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       REQ_VALID;
    logic [N_REQ-1:0]       REQ_READY;
    logic [N_REQ-1:0]       REQ_OP;
    logic [N_REQ*WIDTH-1:0] REQ_A;
    logic [N_REQ*WIDTH-1:0] REQ_B;
    logic                   RSP_VALID;
    logic                   RSP_READY;
    logic [WIDTH-1:0]       RSP_O;
    logic [ID_W-1:0]        RSP_ID;
`ifdef ALU_SHARE_CARRY_OUT_EN
    logic                   RSP_COUT;
`endif

    modport master (
        output REQ_VALID, REQ_OP, REQ_A, REQ_B, RSP_READY,
`ifdef ALU_SHARE_CARRY_OUT_EN
        input  RSP_COUT,
`endif
        input  REQ_READY, RSP_VALID, RSP_O, RSP_ID
    );

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_A, REQ_B, RSP_READY,
`ifdef ALU_SHARE_CARRY_OUT_EN
        output RSP_COUT,
`endif
        output REQ_READY, RSP_VALID, RSP_O, RSP_ID
    );

endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, wrapping at N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  win
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin shared add/sub unit: grant in IDLE, compute in EXEC, hold result in RESP.
// Optional carry/no-borrow output RSP_COUT under ALU_SHARE_CARRY_OUT_EN.
import alu_share_pkg::*;

module alu_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    alu_share_arbiter_if.slave bus
);

`ifdef ALU_SHARE_CARRY_OUT_EN
    localparam int SUM_W = WIDTH + 1;
`else
    localparam int SUM_W = WIDTH;
`endif

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   win;
    logic [N_REQ-1:0]  grant;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              op_q;
    logic [WIDTH-1:0]  b_eff;
    logic [SUM_W-1:0]  sum;
    logic              rsp_vld;
    logic [WIDTH-1:0]  rsp_o;
    logic [ID_W-1:0]   rsp_id;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req    (bus.REQ_VALID),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .win    (win)
    );

    // Subtract is A + ~B + 1; the op bit doubles as the carry-in.
    always_comb begin
        b_eff = (op_q == OP_SUB) ? ~b_q : b_q;
        sum   = SUM_W'(a_q) + SUM_W'(b_eff) + SUM_W'(op_q);
    end

    assign bus.REQ_READY = (state == IDLE && !ASYNCRESET) ? grant : '0;
    assign bus.RSP_VALID = rsp_vld;
    assign bus.RSP_O     = rsp_o;
    assign bus.RSP_ID    = rsp_id;

`ifdef ALU_SHARE_CARRY_OUT_EN
    logic rsp_cout;
    assign bus.RSP_COUT = rsp_cout;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET)
            rsp_cout <= 1'b0;
        else if (state == EXEC)
            rsp_cout <= sum[WIDTH];
    end
`endif

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            rsp_vld <= 1'b0;
            rsp_o   <= '0;
            rsp_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.REQ_VALID) begin
                        a_q   <= bus.REQ_A[win*WIDTH +: WIDTH];
                        b_q   <= bus.REQ_B[win*WIDTH +: WIDTH];
                        op_q  <= bus.REQ_OP[win];
                        id_q  <= win;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_o   <= sum[WIDTH-1:0];
                    rsp_id  <= id_q;
                    rsp_vld <= 1'b1;
                    state   <= RESP;
                end
                RESP: begin
                    // Pointer moves on acceptance so a stalled response keeps its priority slot.
                    if (bus.RSP_READY) begin
                        rsp_vld <= 1'b0;
                        rr_ptr  <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
